matmul_result_drain: RTL and testbench

MATMUL_RESULT_DRAIN -- requirements
Module: matmul_result_drain

---
 rtl/matmul_result_drain.sv | 131 +++++++++++++
 tb/tb_matmul_result_drain.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/matmul_result_drain.sv
// Result buffer for the matmul kernel: gathers one N x N tile from N parallel write banks,
// then streams it out row-major over a valid/ready port once every entry has been written.
module matmul_result_drain #(
    parameter int N  = 16,
    parameter int AW = 4,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          tstart,
    input  logic [AW-1:0] wr_addr [N],
    input  logic          wr_en   [N],
    input  logic [DW-1:0] wr_data [N],
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic [AW-1:0] out_row,
    output logic [AW-1:0] out_col,
    output logic          out_last,
    output logic          done,
    output logic          err_dup,
    output logic          err_late
);
    typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_DRAIN} state_t;

    localparam int            CW     = 2*AW + 1;
    localparam logic [CW-1:0] L_FULL = CW'(N*N);
    localparam logic [AW-1:0] L_MAX  = AW'(N-1);

    state_t        r_state, w_state_nxt;
    logic [DW-1:0] r_mem [N][N];
    logic [N-1:0]  r_written [N];
    logic [CW-1:0] r_cnt, w_cnt_nxt;
    logic [AW:0]   w_inc;
    logic          w_dup, w_any_wr, w_accept, w_last;
    logic [AW-1:0] r_row, r_col;
    logic          r_done, r_err_dup, r_err_late;

    // Banks never collide with each other, so each fresh write adds exactly one unique entry.
    always_comb begin
        w_inc    = '0;
        w_dup    = 1'b0;
        w_any_wr = 1'b0;
        for (int b = 0; b < N; b++) begin
            if (wr_en[b]) begin
                w_any_wr = 1'b1;
                if (r_written[b][wr_addr[b]]) begin
                    w_dup = 1'b1;
                end else begin
                    w_inc = w_inc + (AW+1)'(1);
                end
            end
        end
        w_cnt_nxt = r_cnt + CW'(w_inc);
    end

    assign w_accept = (r_state == S_DRAIN) && out_ready;
    assign w_last   = (r_row == L_MAX) && (r_col == L_MAX);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (tstart) w_state_nxt = S_COLLECT;
            end
            S_COLLECT: begin
                if (tstart)                    w_state_nxt = S_COLLECT;
                else if (w_cnt_nxt == L_FULL)  w_state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                if (tstart)                    w_state_nxt = S_COLLECT;
                else if (w_accept && w_last)   w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_row      <= '0;
            r_col      <= '0;
            r_done     <= 1'b0;
            r_err_dup  <= 1'b0;
            r_err_late <= 1'b0;
            for (int b = 0; b < N; b++) r_written[b] <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= w_accept && w_last && !tstart;
            if (tstart) begin
                r_cnt      <= '0;
                r_row      <= '0;
                r_col      <= '0;
                r_err_dup  <= 1'b0;
                r_err_late <= 1'b0;
                for (int b = 0; b < N; b++) r_written[b] <= '0;
            end else if (r_state == S_COLLECT) begin
                r_cnt <= w_cnt_nxt;
                if (w_dup) r_err_dup <= 1'b1;
                for (int b = 0; b < N; b++) begin
                    if (wr_en[b]) r_written[b][wr_addr[b]] <= 1'b1;
                end
            end else if (r_state == S_DRAIN) begin
                if (w_any_wr) r_err_late <= 1'b1;
                if (w_accept) begin
                    r_col <= r_col + AW'(1);
                    if (r_col == L_MAX) r_row <= r_row + AW'(1);
                end
            end
        end
    end

    // Tile storage is data only: never reset, written solely while collecting.
    always_ff @(posedge clk) begin
        if (!rst && !tstart && (r_state == S_COLLECT)) begin
            for (int b = 0; b < N; b++) begin
                if (wr_en[b]) r_mem[b][wr_addr[b]] <= wr_data[b];
            end
        end
    end

    assign out_valid = (r_state == S_DRAIN);
    assign out_data  = out_valid ? r_mem[r_col][r_row] : '0;
    assign out_row   = r_row;
    assign out_col   = r_col;
    assign out_last  = out_valid && w_last;
    assign done      = r_done;
    assign err_dup   = r_err_dup;
    assign err_late  = r_err_late;
endmodule

// File: tb/tb_matmul_result_drain.sv
// Directed bench for matmul_result_drain: fill, drain, backpressure, duplicate/late writes,
// abort and reset, all checked against a bench-side copy of the written tile.
module tb_matmul_result_drain;
    localparam int N  = 16;
    localparam int AW = 4;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          tstart = 1'b0;
    logic [AW-1:0] wr_addr [N];
    logic          wr_en   [N];
    logic [DW-1:0] wr_data [N];
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_data;
    logic [AW-1:0] out_row, out_col;
    logic          out_last, done, err_dup, err_late;

    logic [DW-1:0] model [N][N];
    int            n_tests = 0;
    int            n_fail  = 0;

    matmul_result_drain #(.N(N), .AW(AW), .DW(DW)) dut (
        .clk(clk), .rst(rst), .tstart(tstart),
        .wr_addr(wr_addr), .wr_en(wr_en), .wr_data(wr_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_row(out_row), .out_col(out_col), .out_last(out_last),
        .done(done), .err_dup(err_dup), .err_late(err_late)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_wr();
        for (int b = 0; b < N; b++) begin
            wr_en[b]   = 1'b0;
            wr_addr[b] = '0;
            wr_data[b] = '0;
        end
    endtask

    // 16 cycles, every bank writes address t with base + b*16 + t; one (bank,addr) may be skipped.
    task automatic fill(input int base, input int skip_b, input int skip_t);
        for (int t = 0; t < N; t++) begin
            for (int b = 0; b < N; b++) begin
                wr_en[b]   = (b == skip_b && t == skip_t) ? 1'b0 : 1'b1;
                wr_addr[b] = AW'(t);
                wr_data[b] = DW'(base + b*N + t);
                if (wr_en[b]) model[b][t] = wr_data[b];
            end
            tick();
        end
        clear_wr();
    endtask

    // mode 0: ready always high, mode 1: ready toggles. abort_at >= 0 aborts (tstart or rst) there.
    task automatic drain(input int mode, input int abort_at, input bit use_rst, input bit late);
        int k = 0;
        int cyc = 0;
        logic [DW-1:0] exp_d;
        while (k < N*N && cyc < 4000) begin
            out_ready = (mode == 0) ? 1'b1 : cyc[0];
            if (late) begin
                wr_en[0]   = (cyc == 3);
                wr_addr[0] = AW'(N-1);
                wr_data[0] = 32'hDEAD_BEEF;
            end
            if (k == abort_at) begin
                out_ready = 1'b0;
                if (use_rst) rst = 1'b1;
                else tstart = 1'b1;
                tick();
                rst = 1'b0;
                tstart = 1'b0;
                return;
            end
            if (out_valid) begin
                exp_d = model[k % N][k / N];
                check("drain_data", 64'(out_data), 64'(exp_d));
                check("drain_idx", 64'({out_row, out_col, out_last}),
                      64'({AW'(k / N), AW'(k % N), (k == N*N-1)}));
                if (out_ready) k++;
            end else begin
                check("drain_valid", 64'(out_valid), 64'd1);
            end
            tick();
            cyc++;
        end
        wr_en[0]  = 1'b0;
        out_ready = 1'b0;
        if (k < N*N) begin
            check("drain_timeout", 64'(k), 64'(N*N));
        end else begin
            check("post_valid", 64'(out_valid), 64'd0);
            check("done_pulse", 64'(done), 64'd1);
            tick();
            check("done_clear", 64'(done), 64'd0);
        end
    endtask

    initial begin
        clear_wr();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_last", 64'(out_last), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_errs", 64'({err_dup, err_late}), 64'd0);
        check("rst_idx", 64'({out_row, out_col}), 64'd0);
        check("rst_data", 64'(out_data), 64'd0);

        // Writes in IDLE must not start a drain.
        fill(5000, -1, -1);
        check("idle_ignore", 64'(out_valid), 64'd0);

        // Full fill, ready always high.
        tstart = 1'b1;
        tick();
        tstart = 1'b0;
        check("collect_valid", 64'(out_valid), 64'd0);
        fill(0, -1, -1);
        check("drain_entry", 64'(out_valid), 64'd1);
        drain(0, -1, 1'b0, 1'b0);
        check("full_errs", 64'({err_dup, err_late}), 64'd0);

        // Writes alongside tstart are discarded; then backpressured drain.
        tstart = 1'b1;
        for (int b = 0; b < N; b++) begin
            wr_en[b]   = 1'b1;
            wr_addr[b] = '0;
            wr_data[b] = 32'h0000_0BAD;
        end
        tick();
        tstart = 1'b0;
        clear_wr();
        fill(1000, -1, -1);
        check("start_discard", 64'(err_dup), 64'd0);
        check("bp_entry", 64'(out_valid), 64'd1);
        drain(1, -1, 1'b0, 1'b0);

        // Duplicate write to bank 3 addr 5, then late write during drain.
        tstart = 1'b1;
        tick();
        tstart = 1'b0;
        wr_en[3] = 1'b1; wr_addr[3] = AW'(5); wr_data[3] = 32'd7;
        tick();
        check("dup_first", 64'(err_dup), 64'd0);
        wr_data[3] = 32'd9;
        tick();
        clear_wr();
        model[3][5] = 32'd9;
        check("dup_set", 64'(err_dup), 64'd1);
        fill(2000, 3, 5);
        check("dup_entry", 64'(out_valid), 64'd1);
        check("dup_data_r5c3", 64'(model[3][5]), 64'd9);
        check("late_clear", 64'(err_late), 64'd0);
        drain(0, -1, 1'b0, 1'b1);
        check("late_set", 64'(err_late), 64'd1);
        check("dup_sticky", 64'(err_dup), 64'd1);

        // Abort at word 40, then a fresh fill drains from word 0.
        tstart = 1'b1;
        tick();
        tstart = 1'b0;
        fill(3000, -1, -1);
        drain(0, 40, 1'b0, 1'b0);
        check("abort_valid", 64'(out_valid), 64'd0);
        check("abort_idx", 64'({out_row, out_col}), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        fill(4000, -1, -1);
        check("refill_entry", 64'(out_valid), 64'd1);
        drain(0, -1, 1'b0, 1'b0);

        // Reset mid-COLLECT, asserted together with tstart.
        tstart = 1'b1;
        tick();
        tstart = 1'b0;
        wr_en[2] = 1'b1; wr_addr[2] = AW'(1); wr_data[2] = 32'd1;
        tick();
        tick();
        clear_wr();
        check("pre_rst_dup", 64'(err_dup), 64'd1);
        rst = 1'b1;
        tstart = 1'b1;
        tick();
        rst = 1'b0;
        tstart = 1'b0;
        check("rst_c_valid", 64'(out_valid), 64'd0);
        check("rst_c_errs", 64'({err_dup, err_late}), 64'd0);
        check("rst_c_data", 64'(out_data), 64'd0);
        fill(5000, -1, -1);
        check("rst_c_idle", 64'(out_valid), 64'd0);

        // Reset mid-DRAIN: no done pulse, then normal operation.
        tstart = 1'b1;
        tick();
        tstart = 1'b0;
        fill(6000, -1, -1);
        drain(0, 100, 1'b1, 1'b0);
        check("rst_d_valid", 64'(out_valid), 64'd0);
        check("rst_d_last", 64'(out_last), 64'd0);
        check("rst_d_done", 64'(done), 64'd0);
        check("rst_d_idx", 64'({out_row, out_col}), 64'd0);
        check("rst_d_data", 64'(out_data), 64'd0);
        tick();
        check("rst_d_nodone", 64'(done), 64'd0);
        tstart = 1'b1;
        tick();
        tstart = 1'b0;
        fill(7000, -1, -1);
        check("post_rst_entry", 64'(out_valid), 64'd1);
        drain(0, -1, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
